fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction fetch stage plus IF/ID pipeline register.
- Owns the PC and drives a request/grant/response instruction-memory port with one outstanding request.
- Delivers the instruction word, its PC and PC+4 to the decode stage, where the immediate generator and control decoder consume the instruction word.
- Supports decode stall, branch/jump redirect (flush), variable memory latency, and a one-entry skid buffer so no fetched word is lost.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
NOP_INST, 32'h0000_0013, bubble inserted on flush/reset (addi x0,x0,0)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address, word aligned
imem_gnt  in  1  memory accepted the request this cycle
imem_rvalid  in  1  response data valid (earliest: cycle after gnt)
imem_rdata  in  32  instruction word
stall  in  1  decode cannot accept a new instruction; hold ID outputs
redirect  in  1  taken branch/jump; flush and refetch
redirect_pc  in  32  redirect target
id_valid  out  1  ID outputs hold a real instruction
id_inst  out  32  instruction word to decode/imm generation
id_pc  out  32  address of id_inst
id_pc_plus4  out  32  id_pc + 4 (link value for JAL/JALR)

Behaviour:
- Reset values (synchronous, also mid-transfer):
  - pc=RESET_PC, state=REQ, skid empty.
  - id_valid=0, id_inst=NOP_INST, id_pc=0, id_pc_plus4=4.
  - Any outstanding response is forgotten; memory must also be reset.
- Registers: pc (next fetch address), req_pc (address of in-flight fetch), skid {valid, inst, pc}.
- accept = !id_valid || !stall. This is the condition under which the ID register loads this cycle.
- FSM states:
  - REQ: imem_req=1 iff skid empty. imem_addr=pc, held stable until gnt. On req&&gnt: req_pc<=pc, pc<=pc+4, go WAIT.
  - WAIT: imem_req=0, except the pipelined case below. On rvalid:
    - if accept: ID register <= {1, rdata, req_pc, req_pc+4};
    - else: skid <= {1, rdata, req_pc}.
    - Pipelined case: if rvalid && accept && skid empty && !redirect, assert imem_req=1, imem_addr=pc in the same cycle. On gnt stay WAIT, otherwise go REQ.
    - Zero-wait memory therefore sustains 1 instruction/cycle.
  - DROP: a request was in flight at redirect. The next rvalid is discarded, then go REQ. imem_req=0.
- Skid drain: when skid valid and accept: ID register <= skid, skid cleared, same cycle. A response arriving in that same cycle then goes to the skid.
- Stall with no response: the ID register holds all values unchanged.
- accept with nothing to load: id_valid<=0, id_inst<=NOP_INST.
- Redirect has highest priority over stall, rvalid and skid. In that cycle:
  - pc<=redirect_pc with bits[1:0] forced to 00.
  - id_valid<=0, id_inst<=NOP_INST; skid cleared.
  - imem_req=0 in that cycle.
  - Next state: from WAIT without rvalid, go DROP. From WAIT with rvalid that cycle, the response is discarded and go REQ. From REQ, DROP is impossible because req=0; go REQ.
  - Redirect while in DROP: stay DROP and update pc.
- Arithmetic: pc+4 and id_pc_plus4 wrap modulo 2^32 (32'hFFFF_FFFC -> 0).
- Protocol errors:
  - rvalid in REQ or with no outstanding request is ignored, with a simulation assertion.
  - gnt without req is ignored.
- Order: instructions reach ID strictly in fetch order. None is duplicated or lost except by redirect/reset.

Decomposition:
- Package fetch_pkg: state enum fetch_state_t {REQ, WAIT, DROP}; NOP_INST and RESET_PC default constants; struct if_id_t {valid, inst, pc, pc_plus4}.
- One sub-module: fetch_skid_buf, a one-entry buffer with load, drain, clear and valid out.

Test Plan:
- Reset, then memory with gnt=1 and 1-cycle rvalid returning addr-tagged words → id_pc sequence 0,4,8,12 on consecutive cycles. id_pc_plus4 tracks +4. id_valid=0 for the first 2 cycles.
- Stall held 3 cycles while a response arrives → ID holds 0x8; response for 0xC goes to skid; imem_req=0. Stall released → id_pc=0xC next cycle, then fetching resumes at 0x10.
- Redirect to 0x103 while a request to 0x20 is outstanding, rvalid 2 cycles later → id_valid=0 and id_inst=0x00000013 next cycle. The 0x20 response is dropped. Next imem_addr=0x100, and first id_pc=0x100.
- Redirect asserted together with stall and a full skid → flush wins: skid empty, id_valid=0, next fetch at target.
- Wrap: redirect to 0xFFFFFFFC → id_pc=0xFFFFFFFC, id_pc_plus4=0, next imem_addr=0.
- Reset asserted in WAIT with a 4-cycle-latency memory → next cycle id_valid=0 and imem_addr=RESET_PC. No stale word reaches ID.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } if_id_t;

    function automatic if_id_t make_if_id(input logic valid, input logic [31:0] inst,
                                          input logic [31:0] pc);
        make_if_id = '{valid: valid, inst: inst, pc: pc, pc_plus4: pc + 32'd4};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Request/grant/response instruction-memory port, one outstanding request.
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding slot for a fetched word that decode could not take yet.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic        drain,
    input  logic [31:0] load_inst,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [31:0] inst,
    output logic [31:0] pc
);

    // A load in the same cycle as a drain refills the slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            inst  <= NOP_INST_DEF;
            pc    <= 32'd0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= load_inst;
            pc    <= load_pc;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register, one outstanding imem request and skid slot.
// state | meaning
// REQ   | presenting pc to memory (held off while skid full)
// WAIT  | request granted, awaiting response; may issue next on response
// DROP  | redirect hit an in-flight request; discard its response
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic          clk,
    input  logic          reset,
    fetch_if.master       imem,
    input  logic          stall,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    output logic          id_valid,
    output logic [31:0]   id_inst,
    output logic [31:0]   id_pc,
    output logic [31:0]   id_pc_plus4
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  req_pc;
    if_id_t       id_q;

    logic         accept;
    logic         resp;
    logic         req;
    logic         fetch_fire;
    logic         skid_valid;
    logic [31:0]  skid_inst;
    logic [31:0]  skid_pc;
    logic         skid_load;
    logic         skid_drain;

    assign accept     = !id_q.valid || !stall;
    assign resp       = imem.imem_rvalid && (state == WAIT);
    assign skid_drain = skid_valid && accept && !redirect;
    assign skid_load  = resp && !redirect && (skid_valid ? accept : !accept);
    assign fetch_fire = req && imem.imem_gnt;

    always_comb begin
        req = 1'b0;
        unique case (state)
            REQ:     req = !skid_valid && !redirect;
            WAIT:    req = resp && accept && !skid_valid && !redirect;
            default: req = 1'b0;
        endcase
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;

    fetch_skid_buf u_skid (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect),
        .load      (skid_load),
        .drain     (skid_drain),
        .load_inst (imem.imem_rdata),
        .load_pc   (req_pc),
        .valid     (skid_valid),
        .inst      (skid_inst),
        .pc        (skid_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= REQ;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
            id_q   <= make_if_id(1'b0, NOP_INST, 32'd0);
        end else if (redirect) begin
            pc         <= redirect_pc & ~32'h3;
            id_q.valid <= 1'b0;
            id_q.inst  <= NOP_INST;
            // A request still in flight must have its response swallowed.
            if ((state == WAIT || state == DROP) && !imem.imem_rvalid)
                state <= DROP;
            else
                state <= REQ;
        end else begin
            if (fetch_fire) begin
                req_pc <= pc;
                pc     <= pc + 32'd4;
            end

            if (skid_drain) begin
                id_q <= make_if_id(1'b1, skid_inst, skid_pc);
            end else if (resp && accept) begin
                id_q <= make_if_id(1'b1, imem.imem_rdata, req_pc);
            end else if (accept) begin
                id_q.valid <= 1'b0;
                id_q.inst  <= NOP_INST;
            end

            unique case (state)
                REQ: begin
                    if (fetch_fire)
                        state <= WAIT;
                end
                WAIT: begin
                    if (imem.imem_rvalid)
                        state <= fetch_fire ? WAIT : REQ;
                end
                DROP: begin
                    if (imem.imem_rvalid)
                        state <= REQ;
                end
                default: state <= REQ;
            endcase
        end
    end

    assign id_valid    = id_q.valid;
    assign id_inst     = id_q.inst;
    assign id_pc       = id_q.pc;
    assign id_pc_plus4 = id_q.pc_plus4;

    rvalid_needs_request: assert property (@(posedge clk) disable iff (reset)
        imem.imem_rvalid |-> (state != REQ));

    skid_never_overflows: assert property (@(posedge clk) disable iff (reset)
        skid_load |-> (!skid_valid || skid_drain));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scenarios plus randomized traffic checked against an in-order fetch model.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    logic        gnt = 1'b1;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'hDEAD_BEEF;

    int checks = 0;
    int errors = 0;
    int unsigned lat = 1;
    bit lat_rand = 1'b0;
    int unsigned cyc = 0;

    fetch_if imem();
    assign imem.imem_gnt    = gnt;
    assign imem.imem_rvalid = mem_rvalid;
    assign imem.imem_rdata  = mem_rdata;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Memory model: requests are sampled mid-cycle, answered after a latency.
    typedef struct {
        int unsigned due;
        logic [31:0] addr;
    } pend_t;
    pend_t q[$];

    logic        req_s = 1'b0;
    logic        gnt_s = 1'b0;
    logic        rst_s = 1'b1;
    logic [31:0] addr_s = 32'd0;

    always @(negedge clk) begin
        #2;
        req_s  = imem.imem_req;
        gnt_s  = gnt;
        rst_s  = reset;
        addr_s = imem.imem_addr;
    end

    always @(posedge clk) begin
        if (rst_s) begin
            q.delete();
        end else begin
            if (mem_rvalid && q.size() > 0) void'(q.pop_front());
            if (req_s && gnt_s)
                q.push_back('{due: cyc + (lat_rand ? $urandom_range(1, 4) : lat), addr: addr_s});
        end
        cyc++;
        #1;
        if (q.size() > 0 && q[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = tag(q[0].addr);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 32'hDEAD_BEEF;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int max_cyc);
        int n = 0;
        while (!id_valid && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, id_valid}, 32'd1);
    endtask

    initial begin
        int n;
        int consumed;
        logic [31:0] exp_pc;

        // Reset values and zero-wait streaming
        lat = 1;
        do_reset();
        chk("rst_valid", id_valid, 0);
        chk("rst_inst", id_inst, 32'h0000_0013);
        chk("rst_pc", id_pc, 0);
        chk("rst_pc4", id_pc_plus4, 4);
        chk("rst_addr", imem.imem_addr, 0);
        chk("rst_req", imem.imem_req, 1);
        @(negedge clk);
        chk("p1_bubble", id_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("p1_valid", id_valid, 1);
            chk("p1_pc", id_pc, 32'(4 * i));
            chk("p1_pc4", id_pc_plus4, 32'(4 * i + 4));
            chk("p1_inst", id_inst, tag(32'(4 * i)));
        end

        // Stall with a response landing in the skid
        do_reset();
        repeat (4) @(negedge clk);
        chk("p2_pc8", id_pc, 32'h8);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("p2_hold_pc", id_pc, 32'h8);
            chk("p2_hold_valid", id_valid, 1);
            chk("p2_req_off", imem.imem_req, 0);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("p2_skid_pc", id_pc, 32'hC);
        chk("p2_skid_inst", id_inst, tag(32'hC));
        chk("p2_resume_req", imem.imem_req, 1);
        chk("p2_resume_addr", imem.imem_addr, 32'h10);
        repeat (2) @(negedge clk);
        chk("p2_pc10", id_pc, 32'h10);

        // Redirect while the request to 0x20 is outstanding
        lat = 3;
        do_reset();
        n = 0;
        while (!(imem.imem_req && imem.imem_addr == 32'h20) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("p3_req20", imem.imem_addr, 32'h20);
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h103;
        #1;
        chk("p3_req_off_redirect", imem.imem_req, 0);
        @(negedge clk);
        redirect = 1'b0;
        chk("p3_flush_valid", id_valid, 0);
        chk("p3_flush_inst", id_inst, 32'h0000_0013);
        chk("p3_drop_req", imem.imem_req, 0);
        repeat (2) @(negedge clk);
        chk("p3_target_req", imem.imem_req, 1);
        chk("p3_target_addr", imem.imem_addr, 32'h100);
        wait_valid("p3_wait_valid", 20);
        chk("p3_first_pc", id_pc, 32'h100);
        chk("p3_first_inst", id_inst, tag(32'h100));

        // Redirect together with stall and a full skid
        lat = 1;
        do_reset();
        repeat (4) @(negedge clk);
        chk("p4_pc8", id_pc, 32'h8);
        stall = 1'b1;
        @(negedge clk);
        chk("p4_skid_full_req", imem.imem_req, 0);
        redirect = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        chk("p4_flush_valid", id_valid, 0);
        chk("p4_flush_inst", id_inst, 32'h0000_0013);
        redirect = 1'b0;
        stall = 1'b0;
        #1;
        chk("p4_skid_empty_req", imem.imem_req, 1);
        chk("p4_target_addr", imem.imem_addr, 32'h200);
        wait_valid("p4_wait_valid", 20);
        chk("p4_first_pc", id_pc, 32'h200);

        // Wrap of pc and link value
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        #1;
        chk("p5_req_off_redirect", imem.imem_req, 0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        n = 0;
        while (!imem.imem_req && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("p5_addr_top", imem.imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("p5_next_req", imem.imem_req, 1);
        chk("p5_next_addr", imem.imem_addr, 32'h0);
        @(negedge clk);
        chk("p5_valid", id_valid, 1);
        chk("p5_pc", id_pc, 32'hFFFF_FFFC);
        chk("p5_pc4", id_pc_plus4, 32'h0);

        // Reset while waiting on a slow response
        lat = 4;
        n = 0;
        while (!(imem.imem_req && imem.imem_addr >= 32'h10 && imem.imem_addr < 32'h100) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("p6_found_req", {31'd0, imem.imem_req}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("p6_rst_valid", id_valid, 0);
        chk("p6_rst_addr", imem.imem_addr, 32'h0);
        chk("p6_rst_inst", id_inst, 32'h0000_0013);
        reset = 1'b0;
        wait_valid("p6_wait_valid", 50);
        chk("p6_first_pc", id_pc, 32'h0);
        chk("p6_first_inst", id_inst, tag(32'h0));

        // Randomized traffic against an in-order stream model
        lat_rand = 1'b1;
        do_reset();
        exp_pc = 32'h0;
        consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            stall       = ($urandom_range(0, 9) < 3);
            redirect    = ($urandom_range(0, 99) < 3);
            redirect_pc = $urandom;
            gnt         = ($urandom_range(0, 9) < 7);
            if (id_valid && !stall) begin
                chk("rnd_pc", id_pc, exp_pc);
                chk("rnd_inst", id_inst, tag(exp_pc));
                chk("rnd_pc4", id_pc_plus4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (redirect) exp_pc = redirect_pc & ~32'h3;
        end
        @(negedge clk);
        stall = 1'b0;
        redirect = 1'b0;
        gnt = 1'b1;
        chk("rnd_progress", {31'd0, consumed > 50}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
